mpc_shared_onchip_memory: RTL and testbench
===========================================

# mpc_shared_onchip_memory

Parametrised multi-port on-chip RAM for the MPC platform: a single physical synchronous RAM shared by `NUM_PORTS` Avalon-MM slave ports (one per core or DMA master) behind a round-robin arbiter. It generalises the fixed 32-bit × 8192 single-port core memory with:

- configurable data width, depth and port count;
- per-port `waitrequest` and pipelined `readdatavalid`;
- byte-enabled writes;
- an optional output register stage.

## Interface

Parameters:
- `NUM_PORTS`, default 2 — number of Avalon-MM slave ports, 1..8.
- `DATA_W`, default 32 — word width; a multiple of 8.
- `DEPTH`, default 8192 — number of words; need not be a power of 2.
- `ADDR_W`, default 13 — word-address width; must satisfy `2**ADDR_W >= DEPTH`.
- `INIT_FILE`, default `""` — hex file loaded with `$readmemh` when non-empty.

Ports:
- `clk` in 1 — the single clock.
- `reset` in 1 — asynchronous, active-high reset.
- `reset_req` in 1 — freezes the block while high; same effect as `clken` low.
- `clken` in 1 — global clock enable.
- `chipselect` in `NUM_PORTS` — per-port select.
- `read` in `NUM_PORTS` — per-port read strobe.
- `write` in `NUM_PORTS` — per-port write strobe.
- `address` in `NUM_PORTS*ADDR_W` — per-port word address; port *i* occupies slice *i*.
- `byteenable` in `NUM_PORTS*DATA_W/8` — per-port byte lanes.
- `writedata` in `NUM_PORTS*DATA_W` — per-port write data.
- `waitrequest` out `NUM_PORTS` — high while the port's request is not accepted.
- `readdata` out `NUM_PORTS*DATA_W` — every slice carries the RAM output word.
- `readdatavalid` out `NUM_PORTS` — one-cycle strobe marking valid read data for that port.

## Operation

- **Request.** Port *i* requests when `chipselect[i] & (read[i] | write[i])`.
  - `read` and `write` both high is treated as a write; the read is dropped and no `readdatavalid` is returned.
- **Enable.** `en = clken & ~reset_req`. When `en` is 0:
  - no grants are issued;
  - every `waitrequest` is high;
  - the read pipeline, pointer and RAM all hold their state.
- **Arbiter.** Round-robin with pointer `ptr`.
  - The search starts at `ptr` and wraps modulo `NUM_PORTS`; the first requesting port wins.
  - After a grant, `ptr = (granted + 1) mod NUM_PORTS`; with no grant, `ptr` holds.
  - `ptr` resets to 0.
  - At most one access per cycle.
- **waitrequest.**
  - Combinational: `waitrequest[i] = ~(en & grant[i])`.
  - A non-requesting port also sees `waitrequest` high. Masters ignore it when idle, per Avalon.
- **Write.**
  - Granted write to `address < DEPTH`: byte lane *b* is written when `byteenable[b]` is set.
  - Write with `address >= DEPTH`: discarded, but still granted (completes normally).
- **Read.**
  - The granted read launches a pipeline token carrying the port index.
  - The RAM output is registered.
  - `address >= DEPTH` returns all zeros.
- **Read-after-write.** A read granted the cycle after a write to the same address returns the new data.
  - Only one access is granted per cycle, so read-during-write on the same cycle never occurs.
- **Reset.** While `reset` is high, and immediately on its assertion:
  - `readdatavalid` = 0, `readdata` = 0, `ptr` = 0;
  - in-flight read tokens are flushed;
  - RAM contents are not cleared.
  - `waitrequest` = all ones while `reset` is high.

## Timing

- Read latency from the grant edge to the `readdatavalid` cycle is `L`:
  - `L` = 1 by default;
  - `L` = 2 with the output register enabled.
- Fixed latency; no back-pressure on read data.
- Tokens are strictly in grant order, so a new read can be granted every cycle.
- A write is accepted in its grant cycle; the RAM is updated on that rising edge.
- Worst-case wait for a continuously requesting port is `NUM_PORTS-1` cycles of grants to other ports.
- A freeze (`en` = 0) stretches latency by the number of frozen cycles; `readdatavalid` is never asserted in a frozen cycle.

## Configuration

- `MPC_SHMEM_OUTREG_EN`:
  - **Defined:** an extra register follows the RAM output. `L` = 2, `readdatavalid` is delayed to match, and reset clears the extra stage.
  - **Undefined:** `L` = 1 and the RAM output register drives `readdata` directly.

## Test plan

- **Single-port access.** `NUM_PORTS`=2. Port 0 writes 0xDEADBEEF to address 5 with `byteenable`=4'hF, then reads address 5 → `waitrequest[0]`=0 in both grant cycles and `readdatavalid[0]` with 0xDEADBEEF exactly `L` cycles after the read grant.
- **Byte lanes.** Write 0x11223344 to address 7, then write 0xAABBCCDD with `byteenable`=4'b0101, then read → 0x11BB33DD.
- **Contention.** Both ports request continuously from reset → grants alternate 0,1,0,1. Each port sees `waitrequest` high on alternate cycles, and each `readdatavalid` goes to the port that issued the read.
- **Boundary.** `DEPTH`=6000. Write 0x12345678 to address 6000, then read 6000 → the write is granted, the read returns 0, and word 5999 is unchanged.
- **Freeze.** Read granted, then `reset_req` high for 3 cycles → no `readdatavalid` during the freeze; data arrives `L` cycles of `en` after the grant.
- **Mid-flight reset.** Assert `reset` one cycle after a read grant → no `readdatavalid` follows, `ptr` = 0, and the first post-reset contention is granted to port 0.

Source files
------------

// File: rtl/mpc_shared_onchip_memory_if.sv
// Avalon-MM bundle for the shared on-chip memory: one slice per port on every
// vector field; port i occupies bits [i*W +: W] of each field.
interface mpc_shared_onchip_memory_if #(
   parameter int NUM_PORTS = 2,
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 13
);
   // Handshake: a port requests with chipselect & (read | write) and must hold
   // the request stable until it sees waitrequest low on a rising edge; that
   // edge accepts it. Read data returns later as a one-cycle readdatavalid
   // strobe, in grant order, with no back-pressure.
   logic [NUM_PORTS-1:0]          chipselect;
   logic [NUM_PORTS-1:0]          read;
   logic [NUM_PORTS-1:0]          write;
   logic [NUM_PORTS*ADDR_W-1:0]   address;
   logic [NUM_PORTS*DATA_W/8-1:0] byteenable;
   logic [NUM_PORTS*DATA_W-1:0]   writedata;
   logic [NUM_PORTS-1:0]          waitrequest;
   logic [NUM_PORTS*DATA_W-1:0]   readdata;
   logic [NUM_PORTS-1:0]          readdatavalid;

   modport master (
      output chipselect, read, write, address, byteenable, writedata,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  chipselect, read, write, address, byteenable, writedata,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/mpc_shared_onchip_memory.sv
// Multi-port synchronous RAM behind a round-robin arbiter, one access per cycle.
// Define MPC_SHMEM_OUTREG_EN to add an output register stage (read latency 2).
module mpc_shared_onchip_memory #(
   parameter int    NUM_PORTS = 2,
   parameter int    DATA_W    = 32,
   parameter int    DEPTH     = 8192,
   parameter int    ADDR_W    = 13,
   parameter string INIT_FILE = ""
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          reset_req,
   input  logic                          clken,
   mpc_shared_onchip_memory_if.slave     bus
);
   localparam int                PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int                BE_W      = DATA_W / 8;
   localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
   localparam logic [PTR_W-1:0]  LAST_PORT = PTR_W'(NUM_PORTS - 1);

   logic                 en;
   logic [NUM_PORTS-1:0] req;
   logic                 gnt_found;
   logic [PTR_W-1:0]     gnt_idx;
   logic [PTR_W-1:0]     cand;
   logic                 acc;
   logic                 acc_wr;
   logic                 acc_rd;
   logic                 in_range;
   logic [ADDR_W-1:0]    acc_addr;
   logic [BE_W-1:0]      acc_be;
   logic [DATA_W-1:0]    acc_wdata;

   logic [DATA_W-1:0]    mem [DEPTH];

   logic [PTR_W-1:0]     ptr_q, ptr_d;
   logic                 rd_vld_q, rd_vld_d;
   logic [PTR_W-1:0]     rd_port_q, rd_port_d;
   logic [DATA_W-1:0]    rd_data_q, rd_data_d;

   logic                 out_vld;
   logic [PTR_W-1:0]     out_port;
   logic [DATA_W-1:0]    out_data;

   assign en  = clken & ~reset_req;
   assign req = bus.chipselect & (bus.read | bus.write);

   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = ptr_q;
      cand      = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         cand = PTR_W'((int'(ptr_q) + k) % NUM_PORTS);
         if (!gnt_found && req[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   assign acc       = en & ~reset & gnt_found;
   assign acc_addr  = bus.address[int'(gnt_idx)*ADDR_W +: ADDR_W];
   assign acc_be    = bus.byteenable[int'(gnt_idx)*BE_W +: BE_W];
   assign acc_wdata = bus.writedata[int'(gnt_idx)*DATA_W +: DATA_W];
   // A simultaneous read+write is a write; the read half is dropped.
   assign acc_wr    = acc & bus.write[gnt_idx];
   assign acc_rd    = acc & bus.read[gnt_idx] & ~bus.write[gnt_idx];
   assign in_range  = {1'b0, acc_addr} < DEPTH_C;

   always_comb begin
      bus.waitrequest = '1;
      if (acc) bus.waitrequest[gnt_idx] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (acc_wr && in_range) begin
         for (int b = 0; b < BE_W; b++) begin
            if (acc_be[b]) mem[acc_addr][b*8 +: 8] <= acc_wdata[b*8 +: 8];
         end
      end
   end

   // Every stage holds while frozen so latency stretches by the frozen cycles.
   always_comb begin
      ptr_d     = ptr_q;
      rd_vld_d  = rd_vld_q;
      rd_port_d = rd_port_q;
      rd_data_d = rd_data_q;
      if (en) begin
         rd_vld_d = acc_rd;
         if (acc_rd) begin
            rd_port_d = gnt_idx;
            rd_data_d = in_range ? mem[acc_addr] : '0;
         end
         if (acc) ptr_d = (gnt_idx == LAST_PORT) ? '0 : gnt_idx + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q     <= '0;
         rd_vld_q  <= 1'b0;
         rd_port_q <= '0;
         rd_data_q <= '0;
      end else begin
         ptr_q     <= ptr_d;
         rd_vld_q  <= rd_vld_d;
         rd_port_q <= rd_port_d;
         rd_data_q <= rd_data_d;
      end
   end

`ifdef MPC_SHMEM_OUTREG_EN
   logic              o_vld_q, o_vld_d;
   logic [PTR_W-1:0]  o_port_q, o_port_d;
   logic [DATA_W-1:0] o_data_q, o_data_d;

   always_comb begin
      o_vld_d  = o_vld_q;
      o_port_d = o_port_q;
      o_data_d = o_data_q;
      if (en) begin
         o_vld_d  = rd_vld_q;
         o_port_d = rd_port_q;
         o_data_d = rd_data_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         o_vld_q  <= 1'b0;
         o_port_q <= '0;
         o_data_q <= '0;
      end else begin
         o_vld_q  <= o_vld_d;
         o_port_q <= o_port_d;
         o_data_q <= o_data_d;
      end
   end

   assign out_vld  = o_vld_q;
   assign out_port = o_port_q;
   assign out_data = o_data_q;
`else
   assign out_vld  = rd_vld_q;
   assign out_port = rd_port_q;
   assign out_data = rd_data_q;
`endif

   // Gated by en so a pending token never strobes during a frozen cycle.
   always_comb begin
      bus.readdatavalid = '0;
      if (en && out_vld) bus.readdatavalid[out_port] = 1'b1;
   end

   assign bus.readdata = {NUM_PORTS{out_data}};
endmodule

// File: tb/tb_mpc_shared_onchip_memory.sv
// Directed bench for mpc_shared_onchip_memory (2 ports, DEPTH 6000); follows
// MPC_SHMEM_OUTREG_EN for the expected read latency.
module tb_mpc_shared_onchip_memory;
   localparam int NP    = 2;
   localparam int DW    = 32;
   localparam int DEPTH = 6000;
   localparam int AW    = 13;
`ifdef MPC_SHMEM_OUTREG_EN
   localparam int L = 2;
`else
   localparam int L = 1;
`endif

   logic clk = 1'b0;
   logic reset;
   logic reset_req;
   logic clken;
   int   checks   = 0;
   int   failures = 0;
   logic [1:0] exp_w;
   logic [1:0] exp_v;
   int   pp;

   always #5 clk = ~clk;

   mpc_shared_onchip_memory_if #(.NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW)) bus ();

   mpc_shared_onchip_memory #(
      .NUM_PORTS(NP), .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .INIT_FILE("")
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .reset_req (reset_req),
      .clken     (clken),
      .bus       (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle_all();
      bus.chipselect = '0;
      bus.read       = '0;
      bus.write      = '0;
      bus.address    = '0;
      bus.byteenable = '0;
      bus.writedata  = '0;
   endtask

   task automatic drive(input int p, input logic rd, input logic wr, input logic [AW-1:0] a,
                        input logic [3:0] be, input logic [31:0] wd);
      bus.chipselect[p]       = 1'b1;
      bus.read[p]             = rd;
      bus.write[p]            = wr;
      bus.address[p*AW +: AW] = a;
      bus.byteenable[p*4 +: 4] = be;
      bus.writedata[p*32 +: 32] = wd;
   endtask

   // Drive one request at the negedge and confirm only that port is granted.
   task automatic issue(input string tag, input int p, input logic rd, input logic wr,
                        input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] wd);
      logic [1:0] ew;
      @(negedge clk);
      idle_all();
      drive(p, rd, wr, a, be, wd);
      #1;
      ew = ~(2'b01 << p);
      chk({tag, " waitrequest"}, 32'(bus.waitrequest), 32'(ew));
   endtask

   task automatic wr(input string tag, input int p, input logic [AW-1:0] a,
                     input logic [3:0] be, input logic [31:0] wd);
      issue(tag, p, 1'b0, 1'b1, a, be, wd);
      @(negedge clk);
      idle_all();
      #1;
      chk({tag, " no readdatavalid"}, 32'(bus.readdatavalid), 32'd0);
   endtask

   task automatic finish_read(input string tag, input int p, input logic [31:0] exp);
      logic [1:0] ev;
      @(negedge clk);
      idle_all();
      for (int k = 1; k < L; k++) begin
         #1;
         chk({tag, " early readdatavalid"}, 32'(bus.readdatavalid), 32'd0);
         @(negedge clk);
      end
      #1;
      ev = 2'b01 << p;
      chk({tag, " readdatavalid"}, 32'(bus.readdatavalid), 32'(ev));
      chk({tag, " readdata"}, bus.readdata[p*32 +: 32], exp);
   endtask

   task automatic rd(input string tag, input int p, input logic [AW-1:0] a, input logic [31:0] exp);
      issue(tag, p, 1'b1, 1'b0, a, 4'h0, 32'h0);
      finish_read(tag, p, exp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_all();
      reset     = 1'b1;
      reset_req = 1'b0;
      clken     = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("reset waitrequest", 32'(bus.waitrequest), 32'h3);
      chk("reset readdatavalid", 32'(bus.readdatavalid), 32'h0);
      chk("reset readdata p0", bus.readdata[31:0], 32'h0);
      chk("reset readdata p1", bus.readdata[63:32], 32'h0);
      @(negedge clk);
      reset = 1'b0;

      wr("single wr", 0, 13'd5, 4'hF, 32'hDEADBEEF);
      rd("single rd", 0, 13'd5, 32'hDEADBEEF);

      wr("lanes wr full", 0, 13'd7, 4'hF, 32'h11223344);
      wr("lanes wr partial", 0, 13'd7, 4'b0101, 32'hAABBCCDD);
      rd("lanes rd", 1, 13'd7, 32'h11BB33DD);

      wr("bound wr last", 1, 13'd5999, 4'hF, 32'hCAFEF00D);
      wr("bound wr over", 0, 13'd6000, 4'hF, 32'h12345678);
      rd("bound rd over", 0, 13'd6000, 32'h0);
      rd("bound rd last", 1, 13'd5999, 32'hCAFEF00D);

      issue("rw both", 0, 1'b1, 1'b1, 13'd11, 4'hF, 32'h77777777);
      @(negedge clk);
      idle_all();
      for (int k = 0; k <= L; k++) begin
         #1;
         chk("rw both no readdatavalid", 32'(bus.readdatavalid), 32'h0);
         @(negedge clk);
      end
      rd("rw both rd", 0, 13'd11, 32'h77777777);

      issue("raw wr", 0, 1'b0, 1'b1, 13'd9, 4'hF, 32'h0BADC0DE);
      issue("raw rd", 0, 1'b1, 1'b0, 13'd9, 4'h0, 32'h0);
      finish_read("raw rd", 0, 32'h0BADC0DE);

      // Freeze: read granted, then three frozen cycles with port 1 waiting.
      issue("freeze rd", 0, 1'b1, 1'b0, 13'd5, 4'h0, 32'h0);
      @(negedge clk);
      idle_all();
      drive(1, 1'b0, 1'b1, 13'd20, 4'hF, 32'h55AA55AA);
      reset_req = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("freeze waitrequest", 32'(bus.waitrequest), 32'h3);
         chk("freeze readdatavalid", 32'(bus.readdatavalid), 32'h0);
         if (k < 2) @(negedge clk);
      end
      @(negedge clk);
      reset_req = 1'b0;
      #1;
      exp_v = (L == 1) ? 2'b01 : 2'b00;
      chk("thaw waitrequest", 32'(bus.waitrequest), 32'h1);
      chk("thaw readdatavalid 1", 32'(bus.readdatavalid), 32'(exp_v));
      @(negedge clk);
      idle_all();
      #1;
      exp_v = (L == 1) ? 2'b00 : 2'b01;
      chk("thaw readdatavalid 2", 32'(bus.readdatavalid), 32'(exp_v));
      chk("thaw readdata", bus.readdata[31:0], 32'hDEADBEEF);
      repeat (2) @(negedge clk);
      rd("frozen wr rd", 1, 13'd20, 32'h55AA55AA);

      // Mid-flight reset: flush the token, then contention from reset.
      issue("midreset rd", 0, 1'b1, 1'b0, 13'd5, 4'h0, 32'h0);
      @(negedge clk);
      idle_all();
      drive(0, 1'b1, 1'b0, 13'd5, 4'h0, 32'h0);
      drive(1, 1'b1, 1'b0, 13'd7, 4'h0, 32'h0);
      reset = 1'b1;
      #1;
      chk("midreset readdatavalid", 32'(bus.readdatavalid), 32'h0);
      chk("midreset readdata", bus.readdata[31:0], 32'h0);
      chk("midreset waitrequest", 32'(bus.waitrequest), 32'h3);
      @(negedge clk);
      #1;
      chk("midreset held readdatavalid", 32'(bus.readdatavalid), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         #1;
         exp_w = (k % 2 == 0) ? 2'b10 : 2'b01;
         chk("contend waitrequest", 32'(bus.waitrequest), 32'(exp_w));
         pp    = (k >= L) ? ((k - L) % 2) : 0;
         exp_v = (k >= L) ? (2'b01 << pp) : 2'b00;
         chk("contend readdatavalid", 32'(bus.readdatavalid), 32'(exp_v));
         if (exp_v != 2'b00)
            chk("contend readdata", bus.readdata[pp*32 +: 32],
                (pp == 0) ? 32'hDEADBEEF : 32'h11BB33DD);
         @(negedge clk);
      end
      idle_all();
      repeat (L + 1) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
